fp_loader: RTL and testbench

- Drives the CPU front-panel programming interface (clear, prog, write, adr, data) from a byte stream, such as a UART receiver.
- Lets a host download a complete 16-byte program into SAP-1 RAM without switches.
- Holds the CPU in clear while loading, validates a checksum, then releases clear so the program runs.
- Sits between the byte source and the sap1 front-panel inputs in top.v.

---
 rtl/fp_loader_if.sv | 25 ++
 rtl/fp_loader.sv | 166 ++++++++++++++++
 tb/tb_fp_loader.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_loader_if.sv
// Byte-source / front-panel bus between fp_loader (master) and its surroundings (slave).
interface fp_loader_if #(parameter int ADDR_WIDTH = 4);
  logic                  start;
  logic                  rx_valid;
  logic [7:0]            rx_data;
  logic                  rx_ready;
  logic [7:0]            mem_rdata;
  logic                  fp_clear;
  logic                  fp_prog;
  logic                  fp_write;
  logic [ADDR_WIDTH-1:0] fp_adr;
  logic [7:0]            fp_data;
  logic                  busy;
  logic                  done;
  logic                  err;

  modport master (
    input  start, rx_valid, rx_data, mem_rdata,
    output rx_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data, busy, done, err
  );
  modport slave (
    output start, rx_valid, rx_data, mem_rdata,
    input  rx_ready, fp_clear, fp_prog, fp_write, fp_adr, fp_data, busy, done, err
  );
endinterface

// File: rtl/fp_loader.sv
// Front-panel program loader for SAP-1: sync byte, 2**ADDR_WIDTH data bytes, two's-complement checksum.
// Optional FP_VERIFY_EN: read back RAM after a good checksum and compare the re-summed contents.
module fp_loader #(
  parameter int         ADDR_WIDTH = 4,
  parameter logic [7:0] SYNC_BYTE  = 8'hA5,
  parameter int         SETUP_CYC  = 1
) (
  input logic         sysclk,
  input logic         reset_n,
  fp_loader_if.master bus
);
  localparam int CW = (SETUP_CYC > 1) ? $clog2(SETUP_CYC) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_SYNC, S_RECV, S_SETUP, S_WRITE, S_HOLD, S_CSUM,
`ifdef FP_VERIFY_EN
    S_VERIFY,
`endif
    S_DONE, S_ERROR
  } state_t;

  state_t                r_state;
  logic                  r_rx_ready, r_clear, r_prog, r_write, r_busy, r_done, r_err;
  logic [ADDR_WIDTH-1:0] r_adr;
  logic [7:0]            r_data, r_sum;
  logic [CW-1:0]         r_cnt;
  logic                  w_xfer, w_last, w_csum_ok;

  assign w_xfer    = bus.rx_valid & r_rx_ready;
  assign w_last    = &r_adr;
  assign w_csum_ok = (bus.rx_data == 8'(~r_sum + 8'd1));

`ifdef FP_VERIFY_EN
  logic       r_phase;
  logic [7:0] r_vsum, w_vsum_nxt;
  assign w_vsum_nxt = r_vsum + bus.mem_rdata;
`else
  logic w_unused_rdata;
  assign w_unused_rdata = ^bus.mem_rdata;
`endif

  always_ff @(posedge sysclk or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_rx_ready <= 1'b0;
      r_clear    <= 1'b1;
      r_prog     <= 1'b0;
      r_write    <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_adr      <= '0;
      r_data     <= '0;
      r_sum      <= '0;
      r_cnt      <= '0;
`ifdef FP_VERIFY_EN
      r_phase    <= 1'b0;
      r_vsum     <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: if (bus.start) begin
          r_state    <= S_SYNC;
          r_busy     <= 1'b1;
          r_rx_ready <= 1'b1;
          r_clear    <= 1'b1;
          r_done     <= 1'b0;
          r_err      <= 1'b0;
        end
        S_SYNC: if (w_xfer && bus.rx_data == SYNC_BYTE) begin
          r_state <= S_RECV;
          r_adr   <= '0;
          r_sum   <= '0;
        end
        S_RECV: if (w_xfer) begin
          r_data     <= bus.rx_data;
          r_sum      <= r_sum + bus.rx_data;
          r_prog     <= 1'b1;
          r_rx_ready <= 1'b0;
          r_cnt      <= CW'(SETUP_CYC - 1);
          r_state    <= S_SETUP;
        end
        S_SETUP: begin
          if (r_cnt == '0) begin
            r_write <= 1'b1;
            r_state <= S_WRITE;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        S_WRITE: begin
          r_write <= 1'b0;
          r_state <= S_HOLD;
        end
        // adr/data held through this cycle so the RAM sees a clean trailing edge
        S_HOLD: begin
          r_rx_ready <= 1'b1;
          if (w_last) begin
            r_prog  <= 1'b0;
            r_state <= S_CSUM;
          end else begin
            r_adr   <= r_adr + 1'b1;
            r_state <= S_RECV;
          end
        end
        S_CSUM: if (w_xfer) begin
          r_rx_ready <= 1'b0;
          if (!w_csum_ok) begin
            r_state <= S_ERROR;
            r_err   <= 1'b1;
            r_busy  <= 1'b0;
          end else begin
`ifdef FP_VERIFY_EN
            r_state <= S_VERIFY;
            r_prog  <= 1'b1;
            r_adr   <= '0;
            r_vsum  <= '0;
            r_phase <= 1'b0;
`else
            r_state <= S_DONE;
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_clear <= 1'b0;
`endif
          end
        end
`ifdef FP_VERIFY_EN
        // first cycle of each address lets the RAM read settle; second cycle samples it
        S_VERIFY: begin
          if (!r_phase) begin
            r_phase <= 1'b1;
          end else begin
            r_phase <= 1'b0;
            r_vsum  <= w_vsum_nxt;
            if (w_last) begin
              r_prog <= 1'b0;
              r_busy <= 1'b0;
              if (w_vsum_nxt == r_sum) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
                r_clear <= 1'b0;
              end else begin
                r_state <= S_ERROR;
                r_err   <= 1'b1;
              end
            end else begin
              r_adr <= r_adr + 1'b1;
            end
          end
        end
`endif
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.rx_ready = r_rx_ready;
  assign bus.fp_clear = r_clear;
  assign bus.fp_prog  = r_prog;
  assign bus.fp_write = r_write;
  assign bus.fp_adr   = r_adr;
  assign bus.fp_data  = r_data;
  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.err      = r_err;
endmodule

// File: tb/tb_fp_loader.sv
// Bench for fp_loader: table of frames plus random frames, checked against a frame-level model.
module tb_fp_loader;
  localparam int AW = 4;
  localparam int N  = 1 << AW;
  localparam logic [7:0] SYNC = 8'hA5;

  logic sysclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 sysclk = ~sysclk;

  fp_loader_if #(.ADDR_WIDTH(AW)) ifc ();
  fp_loader #(.ADDR_WIDTH(AW), .SYNC_BYTE(SYNC), .SETUP_CYC(1)) dut (
    .sysclk (sysclk),
    .reset_n(reset_n),
    .bus    (ifc)
  );

  // RAM model fed by the front-panel strobes; also supplies read-back data
  logic [7:0] ram [N];
  assign ifc.mem_rdata = ram[ifc.fp_adr];

  int         nerr = 0;
  int         nchk = 0;
  logic [7:0] cons [$];
  int         wr_a [$];
  logic [7:0] wr_d [$];
  int         viol = 0;
  logic [AW-1:0] p_adr;
  logic [7:0]    p_dat;
  logic          p_wr = 1'b0;

  // Passive monitor: logs transfers and writes, counts protocol violations
  always @(negedge sysclk) begin
    if (reset_n) begin
      if (ifc.rx_valid && ifc.rx_ready) cons.push_back(ifc.rx_data);
      if (ifc.fp_write) begin
        if (!ifc.fp_prog || ifc.rx_ready || ifc.fp_adr !== p_adr || ifc.fp_data !== p_dat) viol++;
        wr_a.push_back(int'(ifc.fp_adr));
        wr_d.push_back(ifc.fp_data);
        ram[ifc.fp_adr] = ifc.fp_data;
      end
      if (p_wr && (ifc.fp_adr !== p_adr || ifc.fp_data !== p_dat || ifc.fp_write)) viol++;
    end
    p_adr = ifc.fp_adr;
    p_dat = ifc.fp_data;
    p_wr  = ifc.fp_write;
  end

  typedef struct {
    string      name;
    int         kind;    // 0: data=index, 1: all 0x01, 2: random
    int         junk;    // bytes before sync (first two are 0x12, 0x34)
    int         cmode;   // 0: correct csum, 1: fixed cval, 2: corrupted
    logic [7:0] cval;
    bit         bp;      // rx_valid held continuously
    bit         bstart;  // pulse start mid-frame
    int         exp;     // 1 done, 0 err, -1 derive from model
  } vec_t;

  function automatic vec_t mk(string nm, int kind, int junk, int cmode, logic [7:0] cval,
                              bit bp, bit bstart, int exp);
    vec_t v;
    v.name = nm; v.kind = kind; v.junk = junk; v.cmode = cmode; v.cval = cval;
    v.bp = bp; v.bstart = bstart; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge sysclk);
    #1;
  endtask

  task automatic pulse_start();
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input string nm);
    bit got = 1'b0;
    if (gap > 0) begin
      ifc.rx_valid = 1'b0;
      repeat (gap) tick();
    end
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = b;
    for (int n = 0; n < 50 && !got; n++) begin
      @(negedge sysclk);
      got = ifc.rx_ready;
      tick();
    end
    if (!got) chk({nm, ":rx_timeout"}, 0, 1);
  endtask

  task automatic run_frame(input vec_t v);
    logic [7:0] d [N];
    logic [7:0] fr [$];
    logic [7:0] sum = 8'd0;
    logic [7:0] cs;
    logic [7:0] jb;
    int wb = wr_a.size();
    int cb = cons.size();
    int vb = viol;
    int bad;
    int exp_done;
    bit idle = 1'b0;

    for (int i = 0; i < N; i++) begin
      case (v.kind)
        0:       d[i] = 8'(i);
        1:       d[i] = 8'h01;
        default: d[i] = 8'($urandom);
      endcase
      sum = sum + d[i];
    end
    case (v.cmode)
      0:       cs = 8'd0 - sum;
      1:       cs = v.cval;
      default: cs = 8'd1 - sum;
    endcase
    exp_done = (v.exp >= 0) ? v.exp : int'(8'(sum + cs) == 8'd0);

    for (int j = 0; j < v.junk; j++) begin
      if (j == 0) jb = 8'h12;
      else if (j == 1) jb = 8'h34;
      else begin
        jb = 8'($urandom);
        if (jb == SYNC) jb = 8'h5A;
      end
      fr.push_back(jb);
    end
    fr.push_back(SYNC);
    for (int i = 0; i < N; i++) fr.push_back(d[i]);
    fr.push_back(cs);

    ifc.rx_valid = 1'b0;
    pulse_start();
    @(negedge sysclk);
    chk({v.name, ":start_busy"},  ifc.busy, 1);
    chk({v.name, ":start_done"},  ifc.done, 0);
    chk({v.name, ":start_err"},   ifc.err, 0);
    chk({v.name, ":start_clear"}, ifc.fp_clear, 1);
    chk({v.name, ":start_ready"}, ifc.rx_ready, 1);
    tick();

    for (int i = 0; i < fr.size(); i++) begin
      if (v.bstart && i == v.junk + 8) begin
        ifc.rx_valid = 1'b0;
        pulse_start();
      end
      send_byte(fr[i], v.bp ? 0 : int'($urandom_range(0, 2)), v.name);
    end
    ifc.rx_valid = 1'b0;

    for (int n = 0; n < 80 && !idle; n++) begin
      @(negedge sysclk);
      idle = !ifc.busy;
    end
    chk({v.name, ":frame_end"}, idle, 1);
    chk({v.name, ":done"},     ifc.done, exp_done);
    chk({v.name, ":err"},      ifc.err, 1 - exp_done);
    chk({v.name, ":fp_clear"}, ifc.fp_clear, 1 - exp_done);
    chk({v.name, ":fp_prog"},  ifc.fp_prog, 0);
    chk({v.name, ":rx_ready"}, ifc.rx_ready, 0);

    chk({v.name, ":wr_count"}, wr_a.size() - wb, N);
    bad = 0;
    for (int i = 0; i < N; i++) begin
      if (wb + i >= wr_a.size()) bad++;
      else if (wr_a[wb + i] != i || wr_d[wb + i] !== d[i]) bad++;
    end
    chk({v.name, ":wr_seq_bad"}, bad, 0);
    bad = 0;
    for (int i = 0; i < N; i++) if (ram[i] !== d[i]) bad++;
    chk({v.name, ":ram_bad"}, bad, 0);

    chk({v.name, ":rx_count"}, cons.size() - cb, fr.size());
    bad = 0;
    for (int i = 0; i < fr.size(); i++) begin
      if (cb + i >= cons.size()) bad++;
      else if (cons[cb + i] !== fr[i]) bad++;
    end
    chk({v.name, ":rx_seq_bad"}, bad, 0);
    chk({v.name, ":protocol_viol"}, viol - vb, 0);
  endtask

  vec_t tbl [7];

  initial begin
    bit any;
    tbl[0] = mk("good",       0, 0, 1, 8'h88, 1'b0, 1'b0, 1);
    tbl[1] = mk("sync_hunt",  1, 2, 1, 8'hF0, 1'b0, 1'b0, 1);
    tbl[2] = mk("bad_csum",   0, 0, 1, 8'h00, 1'b0, 1'b0, 0);
    tbl[3] = mk("backpress",  0, 0, 1, 8'h88, 1'b1, 1'b0, 1);
    tbl[4] = mk("busy_start", 2, 0, 0, 8'h00, 1'b0, 1'b1, 1);
    tbl[5] = mk("rand_bad",   2, 3, 2, 8'h00, 1'b1, 1'b0, 0);
    tbl[6] = mk("rand_good",  2, 4, 0, 8'h00, 1'b0, 1'b0, 1);

    ifc.start = 1'b0; ifc.rx_valid = 1'b0; ifc.rx_data = 8'h00;
    repeat (2) @(negedge sysclk);
    chk("rst_clear", ifc.fp_clear, 1);
    chk("rst_prog",  ifc.fp_prog, 0);
    chk("rst_write", ifc.fp_write, 0);
    chk("rst_adr",   ifc.fp_adr, 0);
    chk("rst_data",  ifc.fp_data, 0);
    chk("rst_busy",  ifc.busy, 0);
    chk("rst_done",  ifc.done, 0);
    chk("rst_err",   ifc.err, 0);
    chk("rst_ready", ifc.rx_ready, 0);
    tick();
    reset_n = 1'b1;
    tick();

    for (int i = 0; i < 7; i++) run_frame(tbl[i]);
    for (int i = 0; i < 6; i++)
      run_frame(mk("random", 2, int'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0) ? 2 : 0,
                   8'h00, 1'($urandom_range(0, 1)), 1'b0, -1));

    // Reset in the middle of a frame, while waiting for the byte at address 5
    pulse_start();
    send_byte(SYNC, 0, "rst_mid");
    for (int i = 0; i < 5; i++) send_byte(8'(i + 8'h40), 0, "rst_mid");
    ifc.rx_valid = 1'b0;
    any = 1'b0;
    for (int n = 0; n < 10 && !any; n++) begin
      @(negedge sysclk);
      any = ifc.rx_ready;
    end
    chk("mid_ready", any, 1);
    chk("mid_adr",   ifc.fp_adr, 5);
    chk("mid_prog",  ifc.fp_prog, 1);
    chk("mid_busy",  ifc.busy, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_clear", ifc.fp_clear, 1);
    chk("arst_prog",  ifc.fp_prog, 0);
    chk("arst_write", ifc.fp_write, 0);
    chk("arst_adr",   ifc.fp_adr, 0);
    chk("arst_busy",  ifc.busy, 0);
    chk("arst_ready", ifc.rx_ready, 0);
    tick();
    reset_n = 1'b1;
    ifc.rx_valid = 1'b1;
    ifc.rx_data  = SYNC;
    any = 1'b0;
    repeat (3) begin
      @(negedge sysclk);
      any = any | ifc.rx_ready;
    end
    chk("idle_no_ready", any, 0);
    chk("idle_clear", ifc.fp_clear, 1);
    ifc.rx_valid = 1'b0;
    tick();

    run_frame(tbl[0]);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
